// File: rtl/spi_package.sv
// Shared types for the SPI command sequencer.
package spi_package;

    // Sequencer control states.
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StRespond
    } seq_state_e;

endpackage

// File: rtl/spi_command_fifo.sv
// Command FIFO: extra pointer MSB tells full from empty when the index bits match.
module spi_command_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             push_en;
    logic             pop_en;

    // Flags come from registered pointers only, so ready never depends on valid.
    always_comb begin
        full         = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                       (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
        empty_o      = (wr_ptr_q == rd_ptr_q);
        push_ready_o = !full;
        push_en      = push_valid_i && !full;
        pop_en       = pop_i && !empty_o;
        wr_ptr_d     = push_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d     = pop_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        pop_data_o   = mem_q[rd_ptr_q[IdxW-1:0]];
    end

    // Pointer registers; wrap modulo 2*DEPTH by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/spi_command_sequencer.sv
// Queues read/write commands and drives them one at a time into an spi_master.
module spi_command_sequencer
    import spi_package::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 15,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned BUSY_TIMEOUT  = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     command_valid,
    output logic                     command_ready,
    input  logic                     command_read_write,
    input  logic [ADDRESS_WIDTH-1:0] command_address,
    input  logic [DATA_WIDTH-1:0]    command_data,
    output logic                     response_valid,
    input  logic                     response_ready,
    output logic [DATA_WIDTH-1:0]    response_data,
    output logic                     master_enable,
    output logic                     master_read_write,
    output logic [ADDRESS_WIDTH-1:0] master_address,
    output logic [DATA_WIDTH-1:0]    master_data,
    input  logic                     master_busy,
    input  logic [DATA_WIDTH-1:0]    master_read_data,
    output logic                     timeout_error,
    output logic                     sequencer_busy
);
    localparam int unsigned CmdW = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

    seq_state_e               state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     rw_q, rw_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DATA_WIDTH-1:0]    resp_q, resp_d;
    logic                     timeout_q, timeout_d;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [CmdW-1:0]          fifo_data;

    spi_command_fifo #(
        .WIDTH(CmdW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_valid_i(command_valid),
        .push_ready_o(command_ready),
        .push_data_i ({command_read_write, command_address, command_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .empty_o     (fifo_empty)
    );

    // Next-state: pop in IDLE, handshake with the master, capture read data.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        fifo_pop  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop                 = 1'b1;
                    {rw_d, addr_d, data_d}   = fifo_data;
                    state_d                  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (master_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(BUSY_TIMEOUT)) begin
                    // Master never started: flag it and drop the command.
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!master_busy) begin
                    if (rw_q) begin
                        resp_d  = master_read_data;
                        state_d = StRespond;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRespond: begin
                if (response_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        master_enable     = (state_q == StIssue) || (state_q == StWaitBusy);
        master_read_write = rw_q;
        master_address    = addr_q;
        master_data       = data_q;
        response_valid    = (state_q == StRespond);
        response_data     = resp_q;
        timeout_error     = timeout_q;
        sequencer_busy    = (state_q != StIdle) || !fifo_empty;
    end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Self-checking bench for spi_command_sequencer with a behavioural slave model.
module tb_spi_command_sequencer;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam int FD = 4;
    localparam int BT = 255;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          command_valid = 1'b0;
    logic          command_ready;
    logic          command_read_write = 1'b0;
    logic [AW-1:0] command_address = '0;
    logic [DW-1:0] command_data = '0;
    logic          response_valid;
    logic          response_ready;
    logic [DW-1:0] response_data;
    logic          master_enable;
    logic          master_read_write;
    logic [AW-1:0] master_address;
    logic [DW-1:0] master_data;
    logic          master_busy;
    logic [DW-1:0] master_read_data;
    logic          timeout_error;
    logic          sequencer_busy;

    spi_command_sequencer #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .FIFO_DEPTH   (FD),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .command_valid     (command_valid),
        .command_ready     (command_ready),
        .command_read_write(command_read_write),
        .command_address   (command_address),
        .command_data      (command_data),
        .response_valid    (response_valid),
        .response_ready    (response_ready),
        .response_data     (response_data),
        .master_enable     (master_enable),
        .master_read_write (master_read_write),
        .master_address    (master_address),
        .master_data       (master_data),
        .master_busy       (master_busy),
        .master_read_data  (master_read_data),
        .timeout_error     (timeout_error),
        .sequencer_busy    (sequencer_busy)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Scoreboard: what the slave saw, what the consumer accepted.
    cmd_t          got_cmd_q[$];
    logic [DW-1:0] got_resp_q[$];
    int            enable_rises = 0;
    int            valid_cycles = 0;
    logic          en_prev = 1'b0;

    // Knobs set by the test tasks.
    bit            slave_dead = 1'b0;
    bit            override_en = 1'b0;
    logic [DW-1:0] override_val = '0;
    int            len_lo = 1;
    int            rr_mode = 0;

    function automatic logic [DW-1:0] slave_fn(input logic [AW-1:0] a);
        return {a[7:0], ~a[14:7]};
    endfunction

    // Slave model: after a random delay raise busy for a random length, then release.
    int s_state = 0;
    int s_delay = 0;
    int s_len   = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_state          <= 0;
            master_busy      <= 1'b0;
            master_read_data <= '0;
        end else begin
            case (s_state)
                0: if (master_enable && !slave_dead) begin
                    int d;
                    got_cmd_q.push_back({master_read_write, master_address, master_data});
                    master_read_data <= override_en ? override_val : slave_fn(master_address);
                    d = int'($urandom_range(0, 3));
                    s_len <= int'($urandom_range(len_lo, 6));
                    if (d == 0) begin
                        master_busy <= 1'b1;
                        s_state     <= 2;
                    end else begin
                        s_delay <= d;
                        s_state <= 1;
                    end
                end
                1: if (s_delay <= 1) begin
                    master_busy <= 1'b1;
                    s_state     <= 2;
                end else begin
                    s_delay <= s_delay - 1;
                end
                default: if (s_len <= 1) begin
                    master_busy <= 1'b0;
                    s_state     <= 0;
                end else begin
                    s_len <= s_len - 1;
                end
            endcase
        end
    end

    // Observers: enable rising edges, accepted responses, cycles with response_valid.
    always @(posedge clock) begin
        en_prev <= master_enable;
        if (master_enable && !en_prev) enable_rises <= enable_rises + 1;
        if (response_valid) valid_cycles <= valid_cycles + 1;
        if (response_valid && response_ready) got_resp_q.push_back(response_data);
    end

    // Consumer: 0 = never ready, 1 = always ready, else random.
    always @(negedge clock) begin
        case (rr_mode)
            0: response_ready <= 1'b0;
            1: response_ready <= 1'b1;
            default: response_ready <= 1'($urandom_range(0, 1));
        endcase
    end

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.rw   = 1'($urandom_range(0, 1));
        c.addr = AW'($urandom);
        c.data = DW'($urandom);
        return c;
    endfunction

    task automatic push_cmd(input cmd_t c);
        int bound = 0;
        command_valid      = 1'b1;
        command_read_write = c.rw;
        command_address    = c.addr;
        command_data       = c.data;
        while (!command_ready && bound < 2000) begin
            @(negedge clock);
            bound++;
        end
        @(negedge clock);
        command_valid = 1'b0;
        if (bound >= 2000) begin
            total++;
            $display("FAIL push_timeout ready stuck at %b, required 1", command_ready);
        end
    endtask

    task automatic wait_idle();
        int bound = 0;
        while ((sequencer_busy || master_busy || response_valid) && bound < 5000) begin
            @(negedge clock);
            bound++;
        end
        total++;
        if (bound >= 5000) $display("FAIL wait_idle busy=%b, required 0", sequencer_busy);
        else passed++;
    endtask

    task automatic wait_resp_valid();
        int bound = 0;
        while (!response_valid && bound < 2000) begin
            @(negedge clock);
            bound++;
        end
        total++;
        if (!response_valid) $display("FAIL wait_resp_valid got %b, required 1", response_valid);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rr_mode = 0;
        repeat (3) @(negedge clock);
        total++;
        if (command_ready !== 1'b1) $display("FAIL reset_ready got %b, required 1", command_ready);
        else passed++;
        total++;
        if ({master_enable, response_valid, timeout_error, sequencer_busy, master_read_write}
            !== 5'b0)
            $display("FAIL reset_flags got %b, required 00000", {master_enable, response_valid,
                     timeout_error, sequencer_busy, master_read_write});
        else passed++;
        total++;
        if ({master_address, master_data, response_data} !== '0)
            $display("FAIL reset_data got %h, required 0",
                     {master_address, master_data, response_data});
        else passed++;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_write();
        int   be = enable_rises;
        int   bg = got_cmd_q.size();
        int   bv = valid_cycles;
        cmd_t c  = '{rw: 1'b0, addr: 15'h1111, data: 16'h1234};
        push_cmd(c);
        wait_idle();
        total++;
        if (enable_rises - be != 1) $display("FAIL write_enables got %0d, required 1", enable_rises - be);
        else passed++;
        total++;
        if (got_cmd_q.size() != bg + 1 || got_cmd_q[bg] !== c)
            $display("FAIL write_cmd got %0d cmds, required 1 of %h", got_cmd_q.size() - bg, c);
        else passed++;
        total++;
        if (valid_cycles != bv) $display("FAIL write_no_resp got %0d valid cycles, required 0", valid_cycles - bv);
        else passed++;
    endtask

    task automatic test_read();
        int bound = 0;
        override_en  = 1'b1;
        override_val = 16'hA5A5;
        rr_mode      = 0;
        push_cmd('{rw: 1'b1, addr: 15'h1111, data: 16'h0});
        wait_resp_valid();
        total++;
        if (response_data !== 16'hA5A5) $display("FAIL read_data got %h, required a5a5", response_data);
        else passed++;
        repeat (10) @(negedge clock);
        total++;
        if (response_valid !== 1'b1 || response_data !== 16'hA5A5)
            $display("FAIL read_hold got %b/%h, required 1/a5a5", response_valid, response_data);
        else passed++;
        rr_mode = 1;
        while (!response_ready && bound < 10) begin
            @(negedge clock);
            bound++;
        end
        @(posedge clock);
        @(negedge clock);
        total++;
        if (response_valid !== 1'b0) $display("FAIL read_drop got %b, required 0", response_valid);
        else passed++;
        total++;
        if (got_resp_q.size() == 0 || got_resp_q[$] !== 16'hA5A5)
            $display("FAIL read_accept got %0d responses, required last a5a5", got_resp_q.size());
        else passed++;
        override_en = 1'b0;
    endtask

    // Compares the slave's log and accepted responses against the model queues.
    task automatic score(input string tag, input cmd_t ec[$], input logic [DW-1:0] er[$],
                         input int bg, input int br);
        total++;
        if (got_cmd_q.size() - bg != ec.size() || got_resp_q.size() - br != er.size())
            $display("FAIL %s_counts got %0d/%0d, required %0d/%0d", tag, got_cmd_q.size() - bg,
                     got_resp_q.size() - br, ec.size(), er.size());
        else passed++;
        for (int i = 0; i < ec.size() && bg + i < got_cmd_q.size(); i++) begin
            total++;
            if (got_cmd_q[bg + i] !== ec[i])
                $display("FAIL %s_cmd%0d got %h, required %h", tag, i, got_cmd_q[bg + i], ec[i]);
            else passed++;
        end
        for (int i = 0; i < er.size() && br + i < got_resp_q.size(); i++) begin
            total++;
            if (got_resp_q[br + i] !== er[i])
                $display("FAIL %s_resp%0d got %h, required %h", tag, i, got_resp_q[br + i], er[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        cmd_t          ec[$];
        logic [DW-1:0] er[$];
        cmd_t          c;
        int            bg = got_cmd_q.size();
        int            br = got_resp_q.size();
        int            be;
        int            bound = 0;
        rr_mode = 0;
        c = rand_cmd();
        c.rw = 1'b1;
        push_cmd(c);
        ec.push_back(c);
        er.push_back(slave_fn(c.addr));
        wait_resp_valid();
        be = enable_rises;
        for (int i = 0; i < 4; i++) begin
            c = rand_cmd();
            command_valid      = 1'b1;
            command_read_write = c.rw;
            command_address    = c.addr;
            command_data       = c.data;
            total++;
            if (command_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b, required 1", i, command_ready);
            else passed++;
            ec.push_back(c);
            if (c.rw) er.push_back(slave_fn(c.addr));
            @(negedge clock);
        end
        c = rand_cmd();
        command_read_write = c.rw;
        command_address    = c.addr;
        command_data       = c.data;
        total++;
        if (command_ready !== 1'b0) $display("FAIL b2b_full got %b, required 0", command_ready);
        else passed++;
        repeat (3) @(negedge clock);
        total++;
        if (command_ready !== 1'b0 || enable_rises != be)
            $display("FAIL b2b_held got ready %b enables %0d, required 0/0", command_ready,
                     enable_rises - be);
        else passed++;
        rr_mode = 1;
        while (!command_ready && bound < 2000) begin
            @(negedge clock);
            bound++;
        end
        @(negedge clock);
        command_valid = 1'b0;
        ec.push_back(c);
        if (c.rw) er.push_back(slave_fn(c.addr));
        wait_idle();
        score("b2b", ec, er, bg, br);
    endtask

    task automatic test_random();
        cmd_t          ec[$];
        logic [DW-1:0] er[$];
        cmd_t          c;
        int            bg = got_cmd_q.size();
        int            br = got_resp_q.size();
        rr_mode = 2;
        for (int i = 0; i < 24; i++) begin
            c = rand_cmd();
            push_cmd(c);
            ec.push_back(c);
            if (c.rw) er.push_back(slave_fn(c.addr));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_idle();
        score("rand", ec, er, bg, br);
    endtask

    task automatic test_no_reissue();
        int be = enable_rises;
        rr_mode = 0;
        push_cmd('{rw: 1'b1, addr: 15'h0abc, data: 16'h0});
        push_cmd('{rw: 1'b0, addr: 15'h0def, data: 16'h5555});
        wait_resp_valid();
        repeat (50) @(negedge clock);
        total++;
        if (enable_rises - be != 1 || response_valid !== 1'b1)
            $display("FAIL noreissue_hold got %0d enables valid %b, required 1/1",
                     enable_rises - be, response_valid);
        else passed++;
        rr_mode = 1;
        wait_idle();
        total++;
        if (enable_rises - be != 2) $display("FAIL noreissue_after got %0d enables, required 2", enable_rises - be);
        else passed++;
    endtask

    task automatic test_timeout();
        int   bg = got_cmd_q.size();
        int   n = 0;
        int   bound = 0;
        cmd_t c = rand_cmd();
        slave_dead = 1'b1;
        c.rw = 1'b0;
        push_cmd(c);
        while (!master_enable && bound < 100) begin
            @(negedge clock);
            bound++;
        end
        while (!timeout_error && n < 1000) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n < BT || n > BT + 4) $display("FAIL timeout_cycles got %0d, required %0d..%0d", n, BT, BT + 4);
        else passed++;
        total++;
        if (master_enable !== 1'b0 || sequencer_busy !== 1'b0)
            $display("FAIL timeout_idle got en %b busy %b, required 0/0", master_enable, sequencer_busy);
        else passed++;
        slave_dead = 1'b0;
        c = rand_cmd();
        c.rw = 1'b0;
        push_cmd(c);
        wait_idle();
        total++;
        if (got_cmd_q.size() != bg + 1 || got_cmd_q[$] !== c)
            $display("FAIL timeout_next got %0d cmds, required 1 of %h", got_cmd_q.size() - bg, c);
        else passed++;
        total++;
        if (timeout_error !== 1'b1) $display("FAIL timeout_sticky got %b, required 1", timeout_error);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int bound = 0;
        int be;
        rr_mode = 1;
        len_lo  = 5;
        push_cmd('{rw: 1'b1, addr: 15'h0123, data: 16'h0});
        push_cmd('{rw: 1'b0, addr: 15'h0456, data: 16'h7777});
        push_cmd('{rw: 1'b1, addr: 15'h0789, data: 16'h0});
        while (!(master_busy && !master_enable) && bound < 200) begin
            @(negedge clock);
            bound++;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({master_enable, response_valid, timeout_error, sequencer_busy} !== 4'b0 ||
            command_ready !== 1'b1 || {master_address, master_data, response_data} !== '0)
            $display("FAIL midreset_outputs got %b%b%b%b ready %b, required 0000 ready 1",
                     master_enable, response_valid, timeout_error, sequencer_busy, command_ready);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        len_lo  = 1;
        be      = enable_rises;
        repeat (20) @(negedge clock);
        total++;
        if (enable_rises != be || sequencer_busy !== 1'b0)
            $display("FAIL midreset_flushed got %0d enables busy %b, required 0/0",
                     enable_rises - be, sequencer_busy);
        else passed++;
        // Reset while enable is high must drop it without waiting for an edge.
        slave_dead = 1'b1;
        push_cmd('{rw: 1'b0, addr: 15'h0111, data: 16'h2222});
        bound = 0;
        while (!master_enable && bound < 20) begin
            @(negedge clock);
            bound++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (master_enable !== 1'b0) $display("FAIL midreset_async got %b, required 0", master_enable);
        else passed++;
        @(negedge clock);
        reset_n    = 1'b1;
        slave_dead = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_random();
        test_no_reissue();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
